tick_rate_detector: RTL
=======================

# tick_rate_detector

- Measures the spacing between rising edges of a tick stream.
- Recovers the speed code (OFF/SLOW/MEDIUM/FAST = 1/10/100 Hz at CLK_FREQ_HZ) that a speed-selectable tick generator was set to.
- Sits on the receiving side of the tick interface; used for self-check and status readback of the LED state machine's timing path.
- Classification uses tolerance windows, multi-period confirmation and a no-tick timeout.

## Interface

- CLK_FREQ_HZ, 50_000_000, clock frequency. Nominal periods are N1=CLK_FREQ_HZ, N10=CLK_FREQ_HZ/10 and N100=CLK_FREQ_HZ/100, using integer division.
- TOL_PCT, 10, window half-width in percent, legal range 0..50. For each N: LO=N-(N*TOL_PCT)/100 and HI=N+(N*TOL_PCT)/100, inclusive, computed at elaboration with 64-bit intermediates. HI1 must be < 2^32-1.
- LOCK_COUNT, 2, number of consecutive periods with the same class required before speed_detected changes. Legal range 1..15.

- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- tick_in  input  1  tick stream, synchronous to clk. Pulses may be any width; only rising edges count.
- speed_detected  output  2  00 OFF, 01 SLOW, 10 MEDIUM, 11 FAST. Reset 00.
- locked  output  1  the last measured period matched speed_detected. Reset 0.
- period_cycles  output  32  last measured period in clk cycles. Reset 0.
- period_valid  output  1  1-cycle pulse when period_cycles updates. Reset 0.
- period_error  output  1  1-cycle pulse when the measured period falls in no window. Reset 0.

## Operation

- Edge detect: tick_d registers tick_in. rise = tick_in & ~tick_d, evaluated at each clk edge. tick_d resets to 0.
- FSM states:
  - IDLE: entered at reset and on timeout. A rise goes to MEASURE with cnt<=0; no period is reported.
  - MEASURE: cnt increments on every edge without a rise.
- On a rise in MEASURE: P=cnt+1, period_cycles<=P, period_valid<=1, cnt<=0.
- Classification of P, checked in this order: FAST if LO100≤P≤HI100; MEDIUM if in [LO10,HI10]; SLOW if in [LO1,HI1]; otherwise error.
- Confirmation (cand = 2-bit class, conf = 4-bit count, both reset to 0):
  - Class valid and equal to cand: conf<=conf+1, saturating at LOCK_COUNT.
  - Class valid and different from cand: cand<=class, conf<=1.
  - When the new conf value equals LOCK_COUNT: speed_detected<=class.
  - locked<=1 if the class equals the new speed_detected value, else locked<=0.
  - Error: period_error<=1, conf<=0, cand<=00, locked<=0. speed_detected holds.
- Timeout: in MEASURE, at an edge with cnt==HI1 and no rise:
  - speed_detected<=00, locked<=0, conf<=0, cand<=00, state<=IDLE.
  - No period_valid or period_error pulse.
- A rise at the timeout edge takes priority: it is measured as P=HI1+1, which is an error. State stays MEASURE.
- cnt never exceeds HI1, so it cannot overflow.
- tick_in held high produces exactly one rise. A new pulse needs tick_in low for at least one sampled edge.
- Reset asserted mid-measurement returns every register to its reset value immediately. The first rise after release only arms measurement.

## Timing

- Rises sampled at edges k and k+P give period_cycles=P, with period_valid high for the cycle after edge k+P.
- speed_detected, locked and period_error update at that same edge. Detection latency from tick_in to output is one clock.
- Starting from IDLE, speed_detected changes at the (LOCK_COUNT+1)-th rise.
- Timeout: with the last rise at edge k and no further rise, outputs change at edge k+HI1+1.
- period_valid and period_error are never high for more than one cycle. They are mutually exclusive from each other's meaning but co-asserted on an error period, since period_valid pulses for every measured period.

## Test plan

Bench parameters: CLK_FREQ_HZ=1000, TOL_PCT=10, LOCK_COUNT=2. Windows: FAST [9,11], MEDIUM [90,110], SLOW [900,1100].

- Reset, then tick_in=0 for 2000 cycles -> all outputs 0, no pulses.
- 1-cycle pulses every 10 cycles:
  - 1st rise -> nothing.
  - 2nd rise -> period_valid, period_cycles=10, speed_detected 00.
  - 3rd rise -> speed_detected=11, locked=1.
- From FAST lock, switch to a 100-cycle period:
  - 1st period -> speed_detected stays 11, locked=0.
  - 2nd period -> speed_detected=10, locked=1.
  - Then periods 89 and 111 -> period_error each time, speed_detected stays 10, locked=0.
- SLOW lock (period 1000), then stop ticks -> speed_detected=00 and locked=0 exactly 1101 edges after the last rise. The next rise gives no period_valid; two further 1000-cycle periods re-lock SLOW.
- 5-cycle-wide pulses with a 1000-cycle period -> one period_valid per pulse, period_cycles=1000.
- Rise exactly at edge k+1101 -> period_cycles=1101, period_error=1, state remains MEASURE.
- reset_n pulsed low mid-period while locked -> all outputs 0 immediately. The first post-reset rise only arms measurement.

Source files
------------

// File: rtl/tick_rate_detector_if.sv
// Tick-rate detector bus: the observed tick stream and the recovered speed/period status.
interface tick_rate_detector_if;
  logic        tick_in;
  logic [1:0]  speed_detected;
  logic        locked;
  logic [31:0] period_cycles;
  logic        period_valid;
  logic        period_error;

  modport master (
    output tick_in,
    input  speed_detected,
    input  locked,
    input  period_cycles,
    input  period_valid,
    input  period_error
  );

  modport slave (
    input  tick_in,
    output speed_detected,
    output locked,
    output period_cycles,
    output period_valid,
    output period_error
  );
endinterface

// File: rtl/tick_rate_detector.sv
// Measures spacing between tick rising edges and recovers the OFF/SLOW/MEDIUM/FAST speed
// code using tolerance windows, multi-period confirmation and a no-tick timeout.
module tick_rate_detector #(
  parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000,
  parameter int unsigned TOL_PCT     = 32'd10,
  parameter int unsigned LOCK_COUNT  = 32'd2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tick_rate_detector_if.slave  bus
);

  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_FAST = 2'b11;

  localparam logic [63:0] N1    = 64'(CLK_FREQ_HZ);
  localparam logic [63:0] N10   = N1 / 64'd10;
  localparam logic [63:0] N100  = N1 / 64'd100;
  localparam logic [63:0] TOL64 = 64'(TOL_PCT);

  localparam logic [63:0] D1    = (N1 * TOL64) / 64'd100;
  localparam logic [63:0] D10   = (N10 * TOL64) / 64'd100;
  localparam logic [63:0] D100  = (N100 * TOL64) / 64'd100;

  localparam logic [31:0] LO1   = 32'(N1 - D1);
  localparam logic [31:0] HI1   = 32'(N1 + D1);
  localparam logic [31:0] LO10  = 32'(N10 - D10);
  localparam logic [31:0] HI10  = 32'(N10 + D10);
  localparam logic [31:0] LO100 = 32'(N100 - D100);
  localparam logic [31:0] HI100 = 32'(N100 + D100);

  localparam logic [3:0]  LOCK_W = 4'(LOCK_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  // Windows are tested fastest-first so overlapping windows resolve to the shorter period.
  function automatic logic [2:0] classify(input logic [31:0] p);
    logic [2:0] res;
    if ((p >= LO100) && (p <= HI100)) begin
      res = {1'b1, SPD_FAST};
    end else if ((p >= LO10) && (p <= HI10)) begin
      res = {1'b1, SPD_MED};
    end else if ((p >= LO1) && (p <= HI1)) begin
      res = {1'b1, SPD_SLOW};
    end else begin
      res = {1'b0, SPD_OFF};
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic        tick_prev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  conf_q, conf_d;
  logic [1:0]  speed_q, speed_d;
  logic        locked_q, locked_d;
  logic [31:0] period_q, period_d;
  logic        pvalid_q, pvalid_d;
  logic        perr_q, perr_d;

  logic        rise_s;
  logic [31:0] period_s;
  logic        class_ok_s;
  logic [1:0]  class_s;
  logic [3:0]  conf_new_s;
  logic [1:0]  speed_new_s;

  // Rise detection, period classification and the confirmation counter's next value.
  always_comb begin
    rise_s                = bus.tick_in & ~tick_prev_q;
    period_s              = cnt_q + 32'd1;
    {class_ok_s, class_s} = classify(period_s);
    conf_new_s            = 4'd1;
    speed_new_s           = speed_q;
    if (class_s == cand_q) begin
      if (conf_q >= LOCK_W) begin
        conf_new_s = LOCK_W;
      end else begin
        conf_new_s = conf_q + 4'd1;
      end
    end else begin
      conf_new_s = 4'd1;
    end
    if (conf_new_s == LOCK_W) begin
      speed_new_s = class_s;
    end else begin
      speed_new_s = speed_q;
    end
  end

  // Measurement FSM next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    conf_d   = conf_q;
    speed_d  = speed_q;
    locked_d = locked_q;
    period_d = period_q;
    pvalid_d = 1'b0;
    perr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_MEASURE;
          cnt_d   = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          period_d = period_s;
          pvalid_d = 1'b1;
          cnt_d    = 32'd0;
          if (class_ok_s) begin
            cand_d   = class_s;
            conf_d   = conf_new_s;
            speed_d  = speed_new_s;
            locked_d = (class_s == speed_new_s);
          end else begin
            perr_d   = 1'b1;
            conf_d   = 4'd0;
            cand_d   = SPD_OFF;
            locked_d = 1'b0;
          end
        end else if (cnt_q == HI1) begin
          // Nothing can be in range beyond HI1, so stop counting and report OFF.
          state_d  = ST_IDLE;
          cnt_d    = 32'd0;
          speed_d  = SPD_OFF;
          locked_d = 1'b0;
          conf_d   = 4'd0;
          cand_d   = SPD_OFF;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tick_prev_q <= 1'b0;
      cnt_q       <= 32'd0;
      cand_q      <= SPD_OFF;
      conf_q      <= 4'd0;
      speed_q     <= SPD_OFF;
      locked_q    <= 1'b0;
      period_q    <= 32'd0;
      pvalid_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_prev_q <= bus.tick_in;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      conf_q      <= conf_d;
      speed_q     <= speed_d;
      locked_q    <= locked_d;
      period_q    <= period_d;
      pvalid_q    <= pvalid_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.speed_detected = speed_q;
  assign bus.locked         = locked_q;
  assign bus.period_cycles  = period_q;
  assign bus.period_valid   = pvalid_q;
  assign bus.period_error   = perr_q;

endmodule
